// File: rtl/alu_pkg.sv
// Shared constants for the shared-ALU scheduler: ALUctr codes, R-type func codes, FSM states.
package alu_pkg;

  localparam logic [2:0] AluCtrAnd = 3'b000;
  localparam logic [2:0] AluCtrOr  = 3'b001;
  localparam logic [2:0] AluCtrAdd = 3'b010;
  localparam logic [2:0] AluCtrSub = 3'b110;
  localparam logic [2:0] AluCtrSlt = 3'b111;

  localparam logic [5:0] FuncAnd = 6'b100100;
  localparam logic [5:0] FuncOr  = 6'b100101;
  localparam logic [5:0] FuncAdd = 6'b100000;
  localparam logic [5:0] FuncSub = 6'b100010;
  localparam logic [5:0] FuncSlt = 6'b101010;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StResp
  } state_e;

endpackage

// File: rtl/alu_share_sched_if.sv
// Request/response and ALU-side signals of the shared-ALU scheduler.
// slave: the scheduler; master: the issue slots and the ALU instance.
interface alu_share_sched_if #(
  parameter int unsigned WIDTH = 32
);
  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [11:0]        req_func;
  logic [2*WIDTH-1:0] req_a;
  logic [2*WIDTH-1:0] req_b;
  logic [1:0]         rsp_valid;
  logic [1:0]         rsp_ready;
  logic [WIDTH-1:0]   rsp_result;
  logic               rsp_zero;
  logic               rsp_illegal;
  logic               rsp_ovf;
  logic [2:0]         alu_ctr;
  logic [WIDTH-1:0]   alu_a;
  logic [WIDTH-1:0]   alu_b;
  logic [WIDTH-1:0]   alu_result;
  logic               alu_zero;

  modport slave (
    input  req_valid, req_func, req_a, req_b, rsp_ready, alu_result, alu_zero,
    output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_illegal, rsp_ovf,
    output alu_ctr, alu_a, alu_b
  );

  modport master (
    output req_valid, req_func, req_a, req_b, rsp_ready, alu_result, alu_zero,
    input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_illegal, rsp_ovf,
    input  alu_ctr, alu_a, alu_b
  );
endinterface

// File: rtl/alu_func_dec.sv
// R-type func to ALUctr decoder; unsupported funcs report legal_o=0.
module alu_func_dec
  import alu_pkg::*;
(
  input  logic [5:0] func_i,
  output logic       legal_o,
  output logic [2:0] ctr_o
);

  // Pure lookup of the five supported ops
  always_comb begin
    legal_o = 1'b1;
    ctr_o   = AluCtrAnd;
    case (func_i)
      FuncAnd: ctr_o = AluCtrAnd;
      FuncOr:  ctr_o = AluCtrOr;
      FuncAdd: ctr_o = AluCtrAdd;
      FuncSub: ctr_o = AluCtrSub;
      FuncSlt: ctr_o = AluCtrSlt;
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_share_sched.sv
// Round-robin scheduler sharing one ALU between two requesters.
// Optional feature: define ALU_OVF_CHK_EN to capture signed overflow on ADD/SUB into rsp_ovf.
module alu_share_sched
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned ALU_LAT = 0
) (
  input logic              clk,
  input logic              rst,
  alu_share_sched_if.slave bus
);

  // cnt 0 is the grant cycle; cnt 1..LastCnt are the cycles the ALU operands are driven
  localparam logic [2:0] LastCnt = 3'(ALU_LAT + 1);

  state_e           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic             gnt_q, gnt_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [2:0]       op_ctr_q, op_ctr_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [1:0]       req_ready_q, req_ready_d;
  logic [1:0]       rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             illegal_q, illegal_d;
  logic [2:0]       alu_ctr_q, alu_ctr_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;

  logic             gnt_sel;
  logic [5:0]       func_sel;
  logic             dec_legal;
  logic [2:0]       dec_ctr;

  // Arbitration: pointer only breaks ties when both requesters are valid
  always_comb begin
    gnt_sel  = (&bus.req_valid) ? ptr_q : bus.req_valid[1];
    func_sel = gnt_sel ? bus.req_func[11:6] : bus.req_func[5:0];
  end

  alu_func_dec u_dec (
    .func_i  (func_sel),
    .legal_o (dec_legal),
    .ctr_o   (dec_ctr)
  );

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    cnt_d       = cnt_q;
    op_ctr_d    = op_ctr_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    req_ready_d = 2'b00;
    rsp_valid_d = rsp_valid_q;
    result_d    = result_q;
    zero_d      = zero_q;
    illegal_d   = illegal_q;
    alu_ctr_d   = AluCtrAnd;
    alu_a_d     = '0;
    alu_b_d     = '0;
    unique case (state_q)
      StIdle: begin
        if (|bus.req_valid) begin
          req_ready_d = gnt_sel ? 2'b10 : 2'b01;
          gnt_d       = gnt_sel;
          ptr_d       = ~gnt_sel;
          op_ctr_d    = dec_ctr;
          op_a_d      = gnt_sel ? bus.req_a[2*WIDTH-1:WIDTH] : bus.req_a[WIDTH-1:0];
          op_b_d      = gnt_sel ? bus.req_b[2*WIDTH-1:WIDTH] : bus.req_b[WIDTH-1:0];
          cnt_d       = 3'd0;
          state_d     = dec_legal ? StIssue : StResp;
        end
      end
      StIssue: begin
        if (cnt_q == LastCnt) begin
          result_d    = bus.alu_result;
          zero_d      = bus.alu_zero;
          illegal_d   = 1'b0;
          rsp_valid_d = gnt_q ? 2'b10 : 2'b01;
          state_d     = StResp;
        end else begin
          cnt_d     = cnt_q + 3'd1;
          alu_ctr_d = op_ctr_q;
          alu_a_d   = op_a_q;
          alu_b_d   = op_b_q;
        end
      end
      StResp: begin
        // Entering RESP with no response raised yet means the op was illegal
        if (rsp_valid_q == 2'b00) begin
          result_d    = '0;
          zero_d      = 1'b0;
          illegal_d   = 1'b1;
          rsp_valid_d = gnt_q ? 2'b10 : 2'b01;
        end else if (bus.rsp_ready[gnt_q]) begin
          rsp_valid_d = 2'b00;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      ptr_q       <= 1'b0;
      gnt_q       <= 1'b0;
      cnt_q       <= 3'd0;
      op_ctr_q    <= AluCtrAnd;
      op_a_q      <= '0;
      op_b_q      <= '0;
      req_ready_q <= 2'b00;
      rsp_valid_q <= 2'b00;
      result_q    <= '0;
      zero_q      <= 1'b0;
      illegal_q   <= 1'b0;
      alu_ctr_q   <= AluCtrAnd;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      cnt_q       <= cnt_d;
      op_ctr_q    <= op_ctr_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      illegal_q   <= illegal_d;
      alu_ctr_q   <= alu_ctr_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
    end
  end

`ifdef ALU_OVF_CHK_EN
  logic ovf_q;
  logic ovf_calc;
  logic capture;
  logic sign_a, sign_b, sign_r;

  assign capture = (state_q == StIssue) && (cnt_q == LastCnt);

  // Signed overflow from the latched operands and the ALU result; non-arithmetic ops never overflow
  always_comb begin
    sign_a   = op_a_q[WIDTH-1];
    sign_b   = op_b_q[WIDTH-1];
    sign_r   = bus.alu_result[WIDTH-1];
    ovf_calc = 1'b0;
    if (op_ctr_q == AluCtrAdd) begin
      ovf_calc = (sign_a == sign_b) && (sign_r != sign_a);
    end else if (op_ctr_q == AluCtrSub) begin
      ovf_calc = (sign_a != sign_b) && (sign_r != sign_a);
    end
  end

  // Overflow flag is captured alongside the result and cleared for illegal responses
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (capture) begin
      ovf_q <= ovf_calc;
    end else if ((state_q == StResp) && (rsp_valid_q == 2'b00)) begin
      ovf_q <= 1'b0;
    end
  end

  assign bus.rsp_ovf = ovf_q;
`else
  assign bus.rsp_ovf = 1'b0;
`endif

  assign bus.req_ready   = req_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_result  = result_q;
  assign bus.rsp_zero    = zero_q;
  assign bus.rsp_illegal = illegal_q;
  assign bus.alu_ctr     = alu_ctr_q;
  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;

endmodule

// File: tb/tb_alu_share_sched.sv
// Directed bench for alu_share_sched: one instance with ALU_LAT=0, one with ALU_LAT=2,
// each driven by a behavioural ALU. Overflow expectation follows ALU_OVF_CHK_EN.
module tb_alu_share_sched;

  localparam int unsigned W = 32;
`ifdef ALU_OVF_CHK_EN
  localparam logic ExpOvf = 1'b1;
`else
  localparam logic ExpOvf = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  alu_share_sched_if #(.WIDTH(W)) bus0 ();
  alu_share_sched_if #(.WIDTH(W)) bus2 ();

  alu_share_sched #(.WIDTH(W), .ALU_LAT(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  alu_share_sched #(.WIDTH(W), .ALU_LAT(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  function automatic logic [W-1:0] alu_model(input logic [2:0] ctr, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    case (ctr)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return '0;
    endcase
  endfunction

  always_comb begin
    bus0.alu_result = alu_model(bus0.alu_ctr, bus0.alu_a, bus0.alu_b);
    bus0.alu_zero   = (alu_model(bus0.alu_ctr, bus0.alu_a, bus0.alu_b) == '0);
    bus2.alu_result = alu_model(bus2.alu_ctr, bus2.alu_a, bus2.alu_b);
    bus2.alu_zero   = (alu_model(bus2.alu_ctr, bus2.alu_a, bus2.alu_b) == '0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus0.req_valid = '0; bus0.req_func = '0; bus0.req_a = '0; bus0.req_b = '0;
    bus0.rsp_ready = '0;
    bus2.req_valid = '0; bus2.req_func = '0; bus2.req_a = '0; bus2.req_b = '0;
    bus2.rsp_ready = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    n_tests++;
    if ({bus0.req_ready, bus0.rsp_valid, bus0.rsp_zero, bus0.rsp_illegal, bus0.rsp_ovf,
         bus0.alu_ctr} !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_ctl0 got %b want 0", {bus0.req_ready, bus0.rsp_valid, bus0.rsp_zero,
               bus0.rsp_illegal, bus0.rsp_ovf, bus0.alu_ctr});
    end
    n_tests++;
    if ({bus0.rsp_result, bus0.alu_a, bus0.alu_b} !== 96'd0) begin
      n_fail++;
      $display("FAIL reset_data0 got %h want 0", {bus0.rsp_result, bus0.alu_a, bus0.alu_b});
    end
    n_tests++;
    if ({bus2.req_ready, bus2.rsp_valid, bus2.rsp_zero, bus2.rsp_illegal, bus2.rsp_ovf,
         bus2.alu_ctr, bus2.rsp_result, bus2.alu_a, bus2.alu_b} !== 106'd0) begin
      n_fail++;
      $display("FAIL reset_all2 got nonzero outputs want 0");
    end
    rst = 1'b0;
  endtask

  task automatic test_add();
    do_reset();
    bus0.req_valid = 2'b01; bus0.req_func[5:0] = 6'b100000;
    bus0.req_a[31:0] = 32'd5; bus0.req_b[31:0] = 32'd7;
    tick();
    n_tests++;
    if (bus0.req_ready !== 2'b01) begin
      n_fail++; $display("FAIL add_req_ready got %b want 01", bus0.req_ready);
    end
    bus0.req_valid = 2'b00;
    tick();
    n_tests++;
    if ({bus0.alu_ctr, bus0.alu_a, bus0.alu_b, bus0.rsp_valid} !== {3'b010, 32'd5, 32'd7, 2'b00})
    begin
      n_fail++;
      $display("FAIL add_issue got ctr=%b a=%0d b=%0d rv=%b want ctr=010 a=5 b=7 rv=00",
               bus0.alu_ctr, bus0.alu_a, bus0.alu_b, bus0.rsp_valid);
    end
    tick();
    n_tests++;
    if ({bus0.rsp_valid, bus0.rsp_result, bus0.rsp_zero, bus0.alu_ctr} !==
        {2'b01, 32'd12, 1'b0, 3'b000}) begin
      n_fail++;
      $display("FAIL add_rsp got rv=%b res=%0d z=%b ctr=%b want rv=01 res=12 z=0 ctr=000",
               bus0.rsp_valid, bus0.rsp_result, bus0.rsp_zero, bus0.alu_ctr);
    end
    bus0.rsp_ready = 2'b01;
    tick();
    bus0.rsp_ready = 2'b00;
    n_tests++;
    if (bus0.rsp_valid !== 2'b00) begin
      n_fail++; $display("FAIL add_handshake got rv=%b want 00", bus0.rsp_valid);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus0.req_func = {6'b100010, 6'b100010};
    bus0.req_a = {32'd9, 32'd9}; bus0.req_b = {32'd9, 32'd9};
    bus0.req_valid = 2'b11;
    tick();
    n_tests++;
    if (bus0.req_ready !== 2'b01) begin
      n_fail++; $display("FAIL b2b_grant0 got %b want 01", bus0.req_ready);
    end
    bus0.req_valid = 2'b10;
    tick();
    n_tests++;
    if ({bus0.alu_ctr, bus0.req_ready} !== {3'b110, 2'b00}) begin
      n_fail++;
      $display("FAIL b2b_ctr0 got ctr=%b rr=%b want ctr=110 rr=00", bus0.alu_ctr, bus0.req_ready);
    end
    tick();
    n_tests++;
    if ({bus0.rsp_valid, bus0.rsp_result, bus0.rsp_zero} !== {2'b01, 32'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL b2b_rsp0 got rv=%b res=%0d z=%b want rv=01 res=0 z=1",
               bus0.rsp_valid, bus0.rsp_result, bus0.rsp_zero);
    end
    bus0.rsp_ready = 2'b01;
    tick();
    bus0.rsp_ready = 2'b00;
    n_tests++;
    if ({bus0.rsp_valid, bus0.req_ready} !== 4'b0000) begin
      n_fail++;
      $display("FAIL b2b_hs0 got rv=%b rr=%b want 00 00", bus0.rsp_valid, bus0.req_ready);
    end
    tick();
    n_tests++;
    if (bus0.req_ready !== 2'b10) begin
      n_fail++; $display("FAIL b2b_grant1 got %b want 10", bus0.req_ready);
    end
    bus0.req_valid = 2'b00;
    tick();
    n_tests++;
    if (bus0.alu_ctr !== 3'b110) begin
      n_fail++; $display("FAIL b2b_ctr1 got %b want 110", bus0.alu_ctr);
    end
    tick();
    n_tests++;
    if ({bus0.rsp_valid, bus0.rsp_result, bus0.rsp_zero} !== {2'b10, 32'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL b2b_rsp1 got rv=%b res=%0d z=%b want rv=10 res=0 z=1",
               bus0.rsp_valid, bus0.rsp_result, bus0.rsp_zero);
    end
    bus0.rsp_ready = 2'b01;
    tick();
    n_tests++;
    if (bus0.rsp_valid !== 2'b10) begin
      n_fail++; $display("FAIL b2b_wrong_ready got rv=%b want 10", bus0.rsp_valid);
    end
    bus0.rsp_ready = 2'b10;
    tick();
    bus0.rsp_ready = 2'b00;
    n_tests++;
    if (bus0.rsp_valid !== 2'b00) begin
      n_fail++; $display("FAIL b2b_hs1 got rv=%b want 00", bus0.rsp_valid);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    bus0.req_valid = 2'b10; bus0.req_func[11:6] = 6'b000000;
    tick();
    n_tests++;
    if ({bus0.req_ready, bus0.alu_ctr, bus0.rsp_valid} !== {2'b10, 3'b000, 2'b00}) begin
      n_fail++;
      $display("FAIL ill_grant got rr=%b ctr=%b rv=%b want rr=10 ctr=000 rv=00",
               bus0.req_ready, bus0.alu_ctr, bus0.rsp_valid);
    end
    bus0.req_valid = 2'b00;
    tick();
    n_tests++;
    if ({bus0.rsp_valid, bus0.rsp_illegal, bus0.rsp_result, bus0.rsp_zero, bus0.alu_ctr} !==
        {2'b10, 1'b1, 32'd0, 1'b0, 3'b000}) begin
      n_fail++;
      $display("FAIL ill_rsp got rv=%b ill=%b res=%0d z=%b ctr=%b want rv=10 ill=1 res=0 z=0 ctr=000",
               bus0.rsp_valid, bus0.rsp_illegal, bus0.rsp_result, bus0.rsp_zero, bus0.alu_ctr);
    end
    bus0.rsp_ready = 2'b10;
    tick();
    bus0.rsp_ready = 2'b00;
    n_tests++;
    if (bus0.rsp_valid !== 2'b00) begin
      n_fail++; $display("FAIL ill_hs got rv=%b want 00", bus0.rsp_valid);
    end
  endtask

  task automatic test_latency_backpressure();
    do_reset();
    bus2.req_func = {6'b101010, 6'b101010};
    bus2.req_a = {32'd3, 32'hFFFF_FFFF}; bus2.req_b = {32'd4, 32'd1};
    bus2.req_valid = 2'b01;
    tick();
    n_tests++;
    if (bus2.req_ready !== 2'b01) begin
      n_fail++; $display("FAIL lat_grant got %b want 01", bus2.req_ready);
    end
    bus2.req_valid = 2'b00;
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_tests++;
      if ({bus2.rsp_valid, bus2.alu_ctr} !== {2'b00, 3'b111}) begin
        n_fail++;
        $display("FAIL lat_wait%0d got rv=%b ctr=%b want rv=00 ctr=111", i, bus2.rsp_valid,
                 bus2.alu_ctr);
      end
    end
    tick();
    n_tests++;
    if ({bus2.rsp_valid, bus2.rsp_result, bus2.alu_ctr} !== {2'b01, 32'd1, 3'b000}) begin
      n_fail++;
      $display("FAIL lat_rsp got rv=%b res=%0d ctr=%b want rv=01 res=1 ctr=000",
               bus2.rsp_valid, bus2.rsp_result, bus2.alu_ctr);
    end
    bus2.req_valid = 2'b11;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_tests++;
      if ({bus2.rsp_valid, bus2.rsp_result, bus2.rsp_zero, bus2.rsp_illegal, bus2.req_ready} !==
          {2'b01, 32'd1, 1'b0, 1'b0, 2'b00}) begin
        n_fail++;
        $display("FAIL lat_hold%0d got rv=%b res=%0d z=%b ill=%b rr=%b want rv=01 res=1 z=0 ill=0 rr=00",
                 i, bus2.rsp_valid, bus2.rsp_result, bus2.rsp_zero, bus2.rsp_illegal,
                 bus2.req_ready);
      end
    end
    bus2.rsp_ready = 2'b01;
    tick();
    bus2.rsp_ready = 2'b00;
    n_tests++;
    if (bus2.rsp_valid !== 2'b00) begin
      n_fail++; $display("FAIL lat_hs got rv=%b want 00", bus2.rsp_valid);
    end
    tick();
    n_tests++;
    if (bus2.req_ready !== 2'b10) begin
      n_fail++; $display("FAIL lat_waiter_grant got %b want 10", bus2.req_ready);
    end
    bus2.req_valid = 2'b00;
  endtask

  task automatic test_mid_reset();
    do_reset();
    bus0.req_func = {6'b100000, 6'b100000};
    bus0.req_a = {32'd1, 32'd5}; bus0.req_b = {32'd2, 32'd7};
    bus0.req_valid = 2'b01;
    tick();
    bus0.req_valid = 2'b00;
    tick();
    n_tests++;
    if (bus0.alu_ctr !== 3'b010) begin
      n_fail++; $display("FAIL mrst_issue got ctr=%b want 010", bus0.alu_ctr);
    end
    rst = 1'b1;
    tick();
    n_tests++;
    if ({bus0.req_ready, bus0.rsp_valid, bus0.alu_ctr, bus0.alu_a, bus0.alu_b, bus0.rsp_result,
         bus0.rsp_zero, bus0.rsp_illegal, bus0.rsp_ovf} !== 106'd0) begin
      n_fail++;
      $display("FAIL mrst_clear got rr=%b rv=%b ctr=%b a=%0d res=%0d want all 0",
               bus0.req_ready, bus0.rsp_valid, bus0.alu_ctr, bus0.alu_a, bus0.rsp_result);
    end
    rst = 1'b0;
    bus0.req_valid = 2'b11;
    tick();
    n_tests++;
    if ({bus0.req_ready, bus0.rsp_valid} !== {2'b01, 2'b00}) begin
      n_fail++;
      $display("FAIL mrst_regrant got rr=%b rv=%b want rr=01 rv=00", bus0.req_ready,
               bus0.rsp_valid);
    end
    bus0.req_valid = 2'b00;
  endtask

  task automatic test_overflow();
    do_reset();
    bus0.req_valid = 2'b01; bus0.req_func[5:0] = 6'b100000;
    bus0.req_a[31:0] = 32'h7FFF_FFFF; bus0.req_b[31:0] = 32'd1;
    tick();
    bus0.req_valid = 2'b00;
    tick();
    tick();
    n_tests++;
    if ({bus0.rsp_valid, bus0.rsp_result, bus0.rsp_ovf} !== {2'b01, 32'h8000_0000, ExpOvf}) begin
      n_fail++;
      $display("FAIL ovf_add got rv=%b res=%h ovf=%b want rv=01 res=80000000 ovf=%b",
               bus0.rsp_valid, bus0.rsp_result, bus0.rsp_ovf, ExpOvf);
    end
    bus0.rsp_ready = 2'b01;
    tick();
    bus0.rsp_ready = 2'b00;
    bus0.req_valid = 2'b01; bus0.req_func[5:0] = 6'b100100;
    bus0.req_a[31:0] = 32'hFFFF_FFFF; bus0.req_b[31:0] = 32'hFFFF_FFFF;
    tick();
    bus0.req_valid = 2'b00;
    tick();
    tick();
    n_tests++;
    if ({bus0.rsp_valid, bus0.rsp_result, bus0.rsp_ovf} !== {2'b01, 32'hFFFF_FFFF, 1'b0}) begin
      n_fail++;
      $display("FAIL ovf_and got rv=%b res=%h ovf=%b want rv=01 res=ffffffff ovf=0",
               bus0.rsp_valid, bus0.rsp_result, bus0.rsp_ovf);
    end
    bus0.rsp_ready = 2'b01;
    tick();
    bus0.rsp_ready = 2'b00;
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_add();
    test_back_to_back();
    test_illegal();
    test_latency_backpressure();
    test_mid_reset();
    test_overflow();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
